// File: rtl/uart_pkg.sv
// UART receive subsystem shared definitions.
// Holds the receiver FSM state encoding, the par_mode encodings and a
// helper that says whether a par_mode value enables a parity bit.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_RSVD = 2'b11;  // behaves exactly like PAR_NONE

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through receive FIFO with sticky overrun flag.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   wr, din    : write strobe and word
//   rd         : pop the head word (ignored while empty)
//   clr        : clear the sticky overrun flag
//   dout       : head word, forced to zero while empty
//   empty/full : status, level : number of stored words
//   ovr        : sticky, set when a write is dropped because the FIFO is full
module uart_fifo
  import uart_pkg::*;
#(
  parameter int W     = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [W-1:0]             din,
  input  logic                     rd,
  input  logic                     clr,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovr
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));

  // A pop frees a slot in the same edge, so a full FIFO may still accept a
  // write when it is read at the same time.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovr    <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // A fresh overrun takes priority over a clear in the same cycle.
      if (wr && full && !rd) ovr <= 1'b1;
      else if (clr)          ovr <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_subsys.sv
// UART receiver subsystem: baud tick generator, 2-flop rx synchroniser,
// oversampling receive FSM and a FWFT receive FIFO.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   dvsr              : baud divisor, one tick every dvsr+1 clocks
//   par_mode, stop2   : frame format, captured when a start bit is seen
//   rx                : asynchronous serial input, idle high
//   rd_en, clr_err    : pop head word, clear sticky overrun
//   d_out, par_err, frm_err : head word and its error tags
//   rx_empty, rx_full, level, ovr_err : FIFO status
module uart_rx_subsys
  import uart_pkg::*;
#(
  parameter int DBITS  = 8,
  parameter int OVS    = 16,
  parameter int DEPTH  = 16,
  parameter int DVSR_W = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DVSR_W-1:0]      dvsr,
  input  logic [1:0]             par_mode,
  input  logic                   stop2,
  input  logic                   rx,
  input  logic                   rd_en,
  input  logic                   clr_err,
  output logic [DBITS-1:0]       d_out,
  output logic                   par_err,
  output logic                   frm_err,
  output logic                   rx_empty,
  output logic                   rx_full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovr_err
);

  localparam int SW = $clog2(OVS);
  localparam int BW = $clog2(DBITS);
  localparam logic [SW-1:0] MID  = SW'(OVS/2 - 1);
  localparam logic [SW-1:0] LAST = SW'(OVS - 1);
  localparam logic [BW-1:0] NLAST = BW'(DBITS - 1);

  logic [DVSR_W-1:0] tcnt;
  logic [DVSR_W-1:0] dvsr_q;
  logic              tick;
  logic              sync_p0;
  logic              sync_p1;
  logic              rx_s;
  rx_state_t         state;
  rx_state_t         state_nx;
  logic [SW-1:0]     s_cnt;
  logic [BW-1:0]     n_cnt;
  logic [DBITS-1:0]  shreg;
  logic [1:0]        pmode_q;
  logic              stop2_q;
  logic              par_q;
  logic              frm_q;
  logic              bit_pt;
  logic              last_stop;
  logic              wr;
  logic [DBITS+1:0]  wr_word;
  logic [DBITS+1:0]  head;

  // Tick generator: the divisor is re-captured only at wrap so a change
  // never produces a short or long tick period mid-count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt   <= '0;
      dvsr_q <= '0;
    end else if (tcnt == dvsr_q) begin
      tcnt   <= '0;
      dvsr_q <= dvsr;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign tick = (tcnt == dvsr_q);

  // Synchroniser stage p0 -> p1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= rx;
      sync_p1 <= sync_p0;
    end
  end

  assign rx_s = sync_p1;

  assign bit_pt    = tick && (s_cnt == LAST);
  assign last_stop = (n_cnt == BW'(stop2_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (!rx_s) state_nx = ST_START;
      ST_START:  if (tick && (s_cnt == MID)) state_nx = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:   if (bit_pt && (n_cnt == NLAST))
                   state_nx = parity_enabled(pmode_q) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_pt) state_nx = ST_STOP;
      ST_STOP:   if (bit_pt && last_stop) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // The final stop sample is folded in combinationally so the word written
  // carries the framing result of the bit sampled on this very edge.
  always_comb begin
    wr      = (state == ST_STOP) && bit_pt && last_stop;
    wr_word = {frm_q | ~rx_s, par_q, shreg};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_cnt   <= '0;
      n_cnt   <= '0;
      pmode_q <= PAR_NONE;
      stop2_q <= 1'b0;
      par_q   <= 1'b0;
      frm_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            s_cnt   <= '0;
            n_cnt   <= '0;
            pmode_q <= par_mode;
            stop2_q <= stop2;
            par_q   <= 1'b0;
            frm_q   <= 1'b0;
          end
        end
        ST_START: begin
          if (tick) s_cnt <= (s_cnt == MID) ? '0 : s_cnt + 1'b1;
        end
        ST_DATA: begin
          if (bit_pt) begin
            s_cnt <= '0;
            n_cnt <= (n_cnt == NLAST) ? '0 : n_cnt + 1'b1;
          end else if (tick) begin
            s_cnt <= s_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (bit_pt) begin
            s_cnt <= '0;
            // Even: error when XOR is 1; odd: error when XOR is 0.
            par_q <= (^shreg) ^ rx_s ^ (pmode_q == PAR_ODD);
          end else if (tick) begin
            s_cnt <= s_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_pt) begin
            s_cnt <= '0;
            n_cnt <= n_cnt + 1'b1;
            if (!rx_s) frm_q <= 1'b1;
          end else if (tick) begin
            s_cnt <= s_cnt + 1'b1;
          end
        end
        default: s_cnt <= '0;
      endcase
    end
  end

  // LSB arrives first, so bits enter at the top and shift down.
  always_ff @(posedge clk) begin
    if ((state == ST_DATA) && bit_pt) shreg <= {rx_s, shreg[DBITS-1:1]};
  end

  uart_fifo #(
    .W     (DBITS + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (wr),
    .din   (wr_word),
    .rd    (rd_en),
    .clr   (clr_err),
    .dout  (head),
    .empty (rx_empty),
    .full  (rx_full),
    .level (level),
    .ovr   (ovr_err)
  );

  assign {frm_err, par_err, d_out} = head;

endmodule

// File: tb/tb_uart_rx_subsys.sv
module tb_uart_rx_subsys;

  localparam int BIT_CLKS = 128;  // dvsr=7 -> 8 clocks per tick, 16 ticks per bit

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] dvsr;
  logic [1:0]  par_mode;
  logic        stop2;
  logic        rx;
  logic        rd_en;
  logic        clr_err;
  logic [7:0]  d_out;
  logic        par_err;
  logic        frm_err;
  logic        rx_empty;
  logic        rx_full;
  logic [4:0]  level;
  logic        ovr_err;

  logic        mon_rd = 1'b0;
  logic        man_rd = 1'b0;
  logic        auto_read = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_seen_cyc = 0;
  logic [9:0]  exp_q [$];

  assign rd_en = mon_rd | man_rd;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_subsys dut (
    .clk      (clk),
    .reset    (reset),
    .dvsr     (dvsr),
    .par_mode (par_mode),
    .stop2    (stop2),
    .rx       (rx),
    .rd_en    (rd_en),
    .clr_err  (clr_err),
    .d_out    (d_out),
    .par_err  (par_err),
    .frm_err  (frm_err),
    .rx_empty (rx_empty),
    .rx_full  (rx_full),
    .level    (level),
    .ovr_err  (ovr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops and compares every word the FIFO presents while draining.
  initial begin
    logic [9:0] got;
    logic [9:0] want;
    forever begin
      @(negedge clk);
      mon_rd = 1'b0;
      if (auto_read && !rx_empty) begin
        got = {frm_err, par_err, d_out};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_fail++;
            $display("FAIL rx_word: got %0h expected %0h", got, want);
          end
        end
        last_seen_cyc = cyc;
        mon_rd = 1'b1;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    idle(BIT_CLKS);
  endtask

  // A bad stop bit returns high before the end of its bit time so that the
  // receiver, which rearms right after the stop sample, sees a glitch
  // rather than a new start bit.
  task automatic drive_stop(input logic b);
    if (b) begin
      drive_bit(1'b1);
    end else begin
      rx = 1'b0;
      idle(96);
      rx = 1'b1;
      idle(BIT_CLKS - 96);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit use_par, input logic pbit,
                            input bit two_stop, input logic s1, input logic s2);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (use_par) drive_bit(pbit);
    drive_stop(s1);
    if (two_stop) drive_stop(s2);
    drive_bit(1'b1);
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 3000;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    idle(4);
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"}, rx_empty, 1'b1);
    check({tag, "_full"},  rx_full,  1'b0);
    check({tag, "_level"}, level,    5'd0);
    check({tag, "_ovr"},   ovr_err,  1'b0);
    check({tag, "_head"},  {frm_err, par_err, d_out}, 10'h000);
  endtask

  initial begin
    int start_cyc;
    reset    = 1'b1;
    dvsr     = 11'd7;
    par_mode = 2'b00;
    stop2    = 1'b0;
    rx       = 1'b1;
    clr_err  = 1'b0;
    idle(5);
    check_reset_state("rst");
    reset = 1'b0;
    idle(20);
    check_reset_state("post_rst");

    // 8N1 0xA5 with write latency check
    auto_read = 1'b1;
    exp_q.push_back(10'h0A5);
    start_cyc = cyc;
    send_frame(8'hA5, 0, 1'b0, 0, 1'b1, 1'b1);
    wait_drain("drain_a5");
    check("a5_latency_window",
          ((last_seen_cyc - start_cyc) >= 1150) && ((last_seen_cyc - start_cyc) <= 1300), 1'b1);

    // 8E1 and 8O1, 0x07 with parity bit 0
    par_mode = 2'b01;
    exp_q.push_back(10'h107);
    send_frame(8'h07, 1, 1'b0, 0, 1'b1, 1'b1);
    par_mode = 2'b10;
    exp_q.push_back(10'h007);
    send_frame(8'h07, 1, 1'b0, 0, 1'b1, 1'b1);
    wait_drain("drain_parity");

    // 8N2 0x3C with second stop bit 0
    par_mode = 2'b00;
    stop2    = 1'b1;
    exp_q.push_back(10'h23C);
    send_frame(8'h3C, 0, 1'b0, 1, 1'b1, 1'b0);
    stop2 = 1'b0;
    // 8N1 0x81 with its only stop bit 0
    exp_q.push_back(10'h281);
    send_frame(8'h81, 0, 1'b0, 0, 1'b0, 1'b1);
    wait_drain("drain_framing");

    // Start-bit glitch: 40 clocks low
    rx = 1'b0;
    idle(40);
    rx = 1'b1;
    idle(400);
    check("glitch_empty", rx_empty, 1'b1);
    check("glitch_level", level, 5'd0);

    // Format change mid-frame must not affect the frame in flight
    exp_q.push_back(10'h0C3);
    fork
      send_frame(8'hC3, 0, 1'b0, 0, 1'b1, 1'b1);
      begin
        idle(300);
        par_mode = 2'b01;
      end
    join
    par_mode = 2'b00;
    wait_drain("drain_midchange");

    // Pop while empty is ignored
    man_rd = 1'b1;
    idle(1);
    man_rd = 1'b0;
    idle(1);
    check("empty_pop_level", level, 5'd0);
    check("empty_pop_empty", rx_empty, 1'b1);

    // Overrun: 17 frames with no reads
    auto_read = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(10'h010 + 10'(i));
      send_frame(8'h10 + 8'(i), 0, 1'b0, 0, 1'b1, 1'b1);
    end
    idle(10);
    check("ovf_full",  rx_full, 1'b1);
    check("ovf_level", level, 5'd16);
    check("ovf_ovr",   ovr_err, 1'b1);
    check("ovf_head",  {frm_err, par_err, d_out}, 10'h010);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    idle(1);
    check("ovf_clr", ovr_err, 1'b0);
    check("ovf_clr_level", level, 5'd16);
    auto_read = 1'b1;
    wait_drain("drain_overflow");
    check("ovf_drained_empty", rx_empty, 1'b1);

    // Reset in the middle of the data bits, then a clean frame
    rx = 1'b0;
    idle(BIT_CLKS);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    reset = 1'b1;
    idle(5);
    check_reset_state("midrst");
    rx = 1'b1;
    reset = 1'b0;
    idle(2 * BIT_CLKS);
    check("midrst_nowrite", level, 5'd0);
    exp_q.push_back(10'h05A);
    send_frame(8'h5A, 0, 1'b0, 0, 1'b1, 1'b1);
    wait_drain("drain_after_reset");
    idle(600);
    check("after_reset_empty", rx_empty, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish within 100000 cycles");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
